// File: rtl/sram_top.sv
// sram_top: behavioural wrapper around the SRAM bit-cell array.
// Serial write data is collected in a shift register and committed to the
// array on a write request. Reads go through a precharge/sense sequence and
// present the word on data_out with a one-cycle data_valid strobe.
module sram_top #(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            serial_in,
  input  logic            shift,
  input  logic            w_en,
  input  logic            r_en,
  input  logic [AW-1:0]   addr,
  output logic            data_valid,
  output logic [COLS-1:0] data_out
);

  localparam int unsigned ROWS_U = ROWS;
  localparam logic [AW:0] ROWS_W = (AW + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PRECHARGE,
    SENSE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              accept_w;
  logic              accept_r;
  logic [COLS-1:0]   shreg;
  logic [AW-1:0]     addr_l;
  logic [COLS-1:0]   data_l;
  logic              in_range;
  logic [COLS-1:0]   rd_word;
  logic [COLS-1:0]   mem [ROWS];

  // Serial load of write data, MSB first, independent of the FSM.
  always_ff @(posedge clk) begin
    if (arst_n)
      shreg <= '0;
    else if (shift)
      shreg <= {shreg[COLS-2:0], serial_in};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (arst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; requests are only accepted in IDLE and write wins.
  always_comb begin
    state_nx = state;
    accept_w = 1'b0;
    accept_r = 1'b0;
    case (state)
      IDLE: begin
        if (w_en) begin
          accept_w = 1'b1;
          state_nx = WRITE;
        end else if (r_en) begin
          accept_r = 1'b1;
          state_nx = PRECHARGE;
        end
      end
      WRITE:     state_nx = IDLE;
      PRECHARGE: state_nx = SENSE;
      SENSE:     state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Capture address (and pre-shift write data) when a request is accepted.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      addr_l <= '0;
      data_l <= '0;
    end else if (accept_w) begin
      addr_l <= addr;
      data_l <= shreg;
    end else if (accept_r) begin
      addr_l <= addr;
    end
  end

  assign in_range = ({1'b0, addr_l} < ROWS_W);
  assign rd_word  = in_range ? mem[addr_l] : '0;

  // Array update; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      for (int unsigned i = 0; i < ROWS_U; i++)
        mem[i] <= '0;
    end else if (state == WRITE && in_range) begin
      mem[addr_l] <= data_l;
    end
  end

  // Read data output and its one-cycle qualifier.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == SENSE);
      if (state == SENSE)
        data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_top.sv
// Directed testbench for sram_top: reset, serial load, write/read,
// write/read collision, ignored requests and reset during a transaction.
module tb_sram_top;

  logic       clk;
  logic       arst_n;
  logic       serial_in;
  logic       shift;
  logic       w_en;
  logic       r_en;
  logic [3:0] addr;
  logic       data_valid;
  logic [7:0] data_out;

  int n_cmp;
  int n_err;

  sram_top #(.ROWS(16), .COLS(8)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .serial_in  (serial_in),
    .shift      (shift),
    .w_en       (w_en),
    .r_en       (r_en),
    .addr       (addr),
    .data_valid (data_valid),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      shift     = 1'b1;
      serial_in = w[i];
      tick();
    end
    shift     = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a);
    w_en = 1'b1;
    addr = a;
    tick();
    w_en = 1'b0;
    addr = 4'hF;
    tick();
  endtask

  // Read with full latency check: valid only at the second edge after r_en.
  task automatic do_read(input logic [3:0] a, input logic [7:0] expv, input string name);
    r_en = 1'b1;
    addr = a;
    tick();
    r_en = 1'b0;
    addr = ~a;
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_valid1: got %b want 0", name, data_valid);
    end
    tick();
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_valid2: got %b want 0", name, data_valid);
    end
    tick();
    n_cmp++;
    if (data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s valid: got %b want 1", name, data_valid);
    end
    n_cmp++;
    if (data_out !== expv) begin
      n_err++;
      $display("FAIL %s data: got %h want %h", name, data_out, expv);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (data_out !== 8'h00 || data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%b want 00/0", data_out, data_valid);
    end
    arst_n = 1'b0;
    for (int i = 0; i < 16; i++)
      do_read(4'(i), 8'h00, "reset_read");
    tick();
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_read_pulse: got %b want 0", data_valid);
    end
  endtask

  task automatic test_a5();
    shift_word(8'hA5);
    do_write(4'd3);
    do_read(4'd3, 8'hA5, "a5_read");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      shift_word(8'(i) ^ 8'h5A);
      do_write(4'(i));
    end
    for (int i = 0; i < 16; i++)
      do_read(4'(i), 8'(i) ^ 8'h5A, "full_read");
  endtask

  task automatic test_both();
    int pulses;
    shift_word(8'h3C);
    w_en = 1'b1;
    r_en = 1'b1;
    addr = 4'd5;
    tick();
    w_en = 1'b0;
    r_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (data_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL both_no_valid: got %0d pulses want 0", pulses);
    end
    do_read(4'd5, 8'h3C, "both_read");
  endtask

  // r_en held through PRECHARGE/SENSE with a changing addr must be ignored.
  task automatic test_ignore();
    int pulses;
    r_en = 1'b1;
    addr = 4'd2;
    tick();
    addr = 4'd7;
    tick();
    tick();
    r_en = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h58) begin
      n_err++;
      $display("FAIL ignore_first: got %b/%h want 1/58", data_valid, data_out);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL ignore_extra_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    // Reset clears the array first so the aborted write is observable.
    arst_n = 1'b1;
    tick();
    arst_n = 1'b0;
    shift_word(8'hFF);
    w_en = 1'b1;
    addr = 4'd4;
    tick();
    w_en = 1'b0;
    arst_n = 1'b1;
    tick();
    arst_n = 1'b0;
    do_read(4'd4, 8'h00, "rst_in_write");
    // Reset landing on the SENSE edge.
    shift_word(8'hC3);
    do_write(4'd6);
    r_en = 1'b1;
    addr = 4'd6;
    tick();
    r_en = 1'b0;
    tick();
    arst_n = 1'b1;
    tick();
    arst_n = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin
      n_err++;
      $display("FAIL rst_in_sense: got %b/%h want 0/00", data_valid, data_out);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (data_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL rst_in_sense_late: got %0d pulses want 0", pulses);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    arst_n    = 1'b1;
    serial_in = 1'b0;
    shift     = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    addr      = 4'd0;
    #1;
    test_reset();
    test_a5();
    test_full();
    test_both();
    test_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
